// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, scoreboard query and regfile write bundle
interface regfile_wb_arbiter_if #(
   parameter int NREQ       = 3,
   parameter int DATA_SIZE  = 32,
   parameter int SELEC_SIZE = 5
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ*SELEC_SIZE-1:0] req_rd;
   logic [NREQ*DATA_SIZE-1:0]  req_data;
   logic [NREQ-1:0]            req_ready;
   logic                       claim_valid;
   logic [SELEC_SIZE-1:0]      claim_rd;
   logic [SELEC_SIZE-1:0]      query_rs;
   logic [SELEC_SIZE-1:0]      query_rt;
   logic                       busy_s;
   logic                       busy_t;
   logic [SELEC_SIZE-1:0]      wr_rd;
   logic [DATA_SIZE-1:0]       wr_data;
   logic                       wr_we;

   modport master (
      output req_valid, req_rd, req_data, claim_valid, claim_rd, query_rs, query_rt,
      input  req_ready, busy_s, busy_t, wr_rd, wr_data, wr_we
   );

   modport slave (
      input  req_valid, req_rd, req_data, claim_valid, claim_rd, query_rs, query_rt,
      output req_ready, busy_s, busy_t, wr_rd, wr_data, wr_we
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin regfile write-port arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
   parameter int NREQ       = 3,
   parameter int DATA_SIZE  = 32,
   parameter int SELEC_SIZE = 5,
   parameter int ADDRESSES  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_wb_arbiter_if.slave    bus
);
   localparam int PTR_W = $clog2(NREQ);

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]      grant_idx;
   logic [PTR_W:0]        cand;
   logic                  grant_any;
   logic [NREQ-1:0]       grant;
   logic [SELEC_SIZE-1:0] sel_rd;
   logic [DATA_SIZE-1:0]  sel_data;

   logic                  wr_we_q, wr_we_d;
   logic [SELEC_SIZE-1:0] wr_rd_q, wr_rd_d;
   logic [DATA_SIZE-1:0]  wr_data_q, wr_data_d;
   logic [ADDRESSES-1:0]  sb_q, sb_d;

   // Walk the requesters starting at the pointer; the first valid one wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NREQ)) begin
            cand = cand - (PTR_W+1)'(NREQ);
         end
         if (!grant_any && bus.req_valid[cand[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
   end

   assign grant         = grant_any ? (NREQ'(1) << grant_idx) : '0;
   assign bus.req_ready = rst_n ? grant : '0;
   assign sel_rd        = bus.req_rd[grant_idx*SELEC_SIZE +: SELEC_SIZE];
   assign sel_data      = bus.req_data[grant_idx*DATA_SIZE +: DATA_SIZE];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // A grant to r0 still completes the handshake but never reaches the regfile.
   always_comb begin
      wr_we_d   = grant_any && (sel_rd != '0);
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
      if (wr_we_d) begin
         wr_rd_d   = sel_rd;
         wr_data_d = sel_data;
      end
   end

   // Clear first so a same-edge claim of the retiring register keeps it pending.
   always_comb begin
      sb_d = sb_q;
      if (wr_we_q && ({1'b0, wr_rd_q} < (SELEC_SIZE+1)'(ADDRESSES))) begin
         sb_d[wr_rd_q] = 1'b0;
      end
      if (bus.claim_valid && (bus.claim_rd != '0) &&
          ({1'b0, bus.claim_rd} < (SELEC_SIZE+1)'(ADDRESSES))) begin
         sb_d[bus.claim_rd] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         wr_we_q   <= 1'b0;
         wr_rd_q   <= '0;
         wr_data_q <= '0;
         sb_q      <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wr_we_q   <= wr_we_d;
         wr_rd_q   <= wr_rd_d;
         wr_data_q <= wr_data_d;
         sb_q      <= sb_d;
      end
   end

   assign bus.busy_s  = ({1'b0, bus.query_rs} < (SELEC_SIZE+1)'(ADDRESSES)) ? sb_q[bus.query_rs] : 1'b0;
   assign bus.busy_t  = ({1'b0, bus.query_rt} < (SELEC_SIZE+1)'(ADDRESSES)) ? sb_q[bus.query_rt] : 1'b0;
   assign bus.wr_we   = wr_we_q;
   assign bus.wr_rd   = wr_rd_q;
   assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int SW   = 5;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [SW+DW-1:0] exp_q[$];
   logic [SW+DW-1:0] exp_item;
   logic [DW-1:0]    regfile [32];

   regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_SIZE(DW), .SELEC_SIZE(SW)) bus ();

   regfile_wb_arbiter #(.NREQ(NREQ), .DATA_SIZE(DW), .SELEC_SIZE(SW), .ADDRESSES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.wr_we === 1'b1) regfile[bus.wr_rd] <= bus.wr_data;
   end

   task automatic set_req(input int i, input logic [SW-1:0] rd, input logic [DW-1:0] data);
      bus.req_rd[i*SW +: SW]   = rd;
      bus.req_data[i*DW +: DW] = data;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.req_valid   = 3'b111;
      bus.claim_valid = 1'b1;
      bus.claim_rd    = 5'd3;
      bus.query_rs    = 5'd3;
      bus.query_rt    = 5'd3;
      for (int i = 0; i < NREQ; i++) set_req(i, SW'(i + 1), DW'(32'hA000 + i));
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.req_ready !== 3'b000) begin
         errors++; $display("FAIL reset_ready got %b want 000", bus.req_ready);
      end
      checks++;
      if (bus.wr_we !== 1'b0 || bus.wr_rd !== 5'd0 || bus.wr_data !== 32'd0) begin
         errors++; $display("FAIL reset_wr got we=%b rd=%0d data=%h want 0/0/0", bus.wr_we, bus.wr_rd, bus.wr_data);
      end
      checks++;
      if (bus.busy_s !== 1'b0 || bus.busy_t !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b%b want 00", bus.busy_s, bus.busy_t);
      end
      bus.req_valid   = '0;
      bus.claim_valid = 1'b0;
      rst_n           = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_ready;
      logic [SW-1:0]   rds [NREQ];
      logic [DW-1:0]   dats[NREQ];
      for (int i = 0; i < NREQ; i++) begin
         rds[i]  = SW'(i + 1);
         dats[i] = DW'(32'hC0DE_0000 + 32'(i) * 32'h11);
         set_req(i, rds[i], dats[i]);
      end
      bus.req_valid = 3'b111;
      #1;
      for (int c = 0; c < 6; c++) begin
         exp_ready = NREQ'(1) << (c % NREQ);
         checks++;
         if (bus.req_ready !== exp_ready) begin
            errors++; $display("FAIL rr_grant cycle %0d got %b want %b", c, bus.req_ready, exp_ready);
         end
         exp_q.push_back({rds[c % NREQ], dats[c % NREQ]});
         @(posedge clk); #2;
         checks++;
         if (bus.wr_we !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL rr_we cycle %0d got %b want 1", c, bus.wr_we);
         end else begin
            exp_item = exp_q.pop_front();
            if ({bus.wr_rd, bus.wr_data} !== exp_item) begin
               errors++; $display("FAIL rr_write cycle %0d got rd=%0d data=%h want rd=%0d data=%h",
                                  c, bus.wr_rd, bus.wr_data, exp_item[DW +: SW], exp_item[DW-1:0]);
            end
         end
      end
      bus.req_valid = '0;
      @(posedge clk); #2;
      checks++;
      if (bus.wr_we !== 1'b0) begin
         errors++; $display("FAIL rr_idle_we got %b want 0", bus.wr_we);
      end
   endtask

   task automatic test_single();
      set_req(2, 5'd7, 32'hDEADBEEF);
      bus.req_valid = 3'b100;
      #1;
      checks++;
      if (bus.req_ready !== 3'b100) begin
         errors++; $display("FAIL single_ready got %b want 100", bus.req_ready);
      end
      exp_q.push_back({5'd7, 32'hDEADBEEF});
      @(posedge clk); #1;
      bus.req_valid = '0;
      #1;
      checks++;
      if (bus.wr_we !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL single_we got %b want 1", bus.wr_we);
      end else begin
         exp_item = exp_q.pop_front();
         if ({bus.wr_rd, bus.wr_data} !== exp_item) begin
            errors++; $display("FAIL single_write got rd=%0d data=%h want rd=%0d data=%h",
                               bus.wr_rd, bus.wr_data, exp_item[DW +: SW], exp_item[DW-1:0]);
         end
      end
      @(posedge clk); #2;
   endtask

   task automatic test_scoreboard();
      bus.query_rs    = 5'd9;
      bus.query_rt    = 5'd10;
      bus.claim_valid = 1'b1;
      bus.claim_rd    = 5'd9;
      @(posedge clk); #1;
      bus.claim_valid = 1'b0;
      #1;
      checks++;
      if (bus.busy_s !== 1'b1 || bus.busy_t !== 1'b0) begin
         errors++; $display("FAIL sb_claim got s=%b t=%b want 1 0", bus.busy_s, bus.busy_t);
      end
      set_req(0, 5'd9, 32'h9999_0009);
      bus.req_valid = 3'b001;
      exp_q.push_back({5'd9, 32'h9999_0009});
      @(posedge clk); #1;
      bus.req_valid = '0;
      #1;
      checks++;
      if (bus.wr_we !== 1'b1 || bus.busy_s !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL sb_inflight got we=%b busy=%b want 1 1", bus.wr_we, bus.busy_s);
      end else begin
         exp_item = exp_q.pop_front();
         if ({bus.wr_rd, bus.wr_data} !== exp_item) begin
            errors++; $display("FAIL sb_write got rd=%0d data=%h want rd=%0d data=%h",
                               bus.wr_rd, bus.wr_data, exp_item[DW +: SW], exp_item[DW-1:0]);
         end
      end
      @(posedge clk); #2;
      checks++;
      if (bus.busy_s !== 1'b0 || regfile[9] !== 32'h9999_0009) begin
         errors++; $display("FAIL sb_retire got busy=%b rf9=%h want 0 99990009", bus.busy_s, regfile[9]);
      end
   endtask

   task automatic test_collision();
      bus.query_rt    = 5'd5;
      bus.claim_valid = 1'b1;
      bus.claim_rd    = 5'd5;
      set_req(1, 5'd5, 32'h5555_AAAA);
      bus.req_valid   = 3'b010;
      exp_q.push_back({5'd5, 32'h5555_AAAA});
      @(posedge clk); #1;
      bus.req_valid = '0;
      #1;
      checks++;
      if (bus.wr_we !== 1'b1 || bus.busy_t !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL coll_inflight got we=%b busy=%b want 1 1", bus.wr_we, bus.busy_t);
      end else begin
         exp_item = exp_q.pop_front();
         if ({bus.wr_rd, bus.wr_data} !== exp_item) begin
            errors++; $display("FAIL coll_write got rd=%0d data=%h want rd=%0d data=%h",
                               bus.wr_rd, bus.wr_data, exp_item[DW +: SW], exp_item[DW-1:0]);
         end
      end
      @(posedge clk); #1;
      bus.claim_valid = 1'b0;
      #1;
      checks++;
      if (bus.busy_t !== 1'b1 || bus.wr_we !== 1'b0) begin
         errors++; $display("FAIL coll_set_wins got busy=%b we=%b want 1 0", bus.busy_t, bus.wr_we);
      end
   endtask

   task automatic test_reg0();
      bus.query_rs    = 5'd0;
      bus.claim_valid = 1'b1;
      bus.claim_rd    = 5'd0;
      set_req(1, 5'd0, 32'h0000_1234);
      bus.req_valid   = 3'b010;
      #1;
      checks++;
      if (bus.req_ready !== 3'b010) begin
         errors++; $display("FAIL reg0_ready got %b want 010", bus.req_ready);
      end
      @(posedge clk); #1;
      bus.req_valid   = '0;
      bus.claim_valid = 1'b0;
      #1;
      checks++;
      if (bus.wr_we !== 1'b0 || bus.busy_s !== 1'b0 || bus.wr_rd !== 5'd5) begin
         errors++; $display("FAIL reg0_nowrite got we=%b busy=%b rd=%0d want 0 0 5", bus.wr_we, bus.busy_s, bus.wr_rd);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL queue_drained got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      bus.query_rs = 5'd5;
      for (int i = 0; i < NREQ; i++) set_req(i, SW'(20 + i), DW'(32'hF00 + i));
      bus.req_valid = 3'b111;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if (bus.req_ready !== 3'b000 || bus.wr_we !== 1'b0) begin
         errors++; $display("FAIL midreset_out got ready=%b we=%b want 000 0", bus.req_ready, bus.wr_we);
      end
      checks++;
      if (bus.busy_s !== 1'b0 || bus.busy_t !== 1'b0) begin
         errors++; $display("FAIL midreset_busy got %b%b want 00", bus.busy_s, bus.busy_t);
      end
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #2;
      checks++;
      if (bus.wr_we !== 1'b0) begin
         errors++; $display("FAIL midreset_release_we got %b want 0", bus.wr_we);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst_n           = 1'b0;
      bus.req_valid   = '0;
      bus.req_rd      = '0;
      bus.req_data    = '0;
      bus.claim_valid = 1'b0;
      bus.claim_rd    = '0;
      bus.query_rs    = '0;
      bus.query_rt    = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_scoreboard();
      test_collision();
      test_reg0();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
